// File: rtl/entry_seq.sv
// Two-operand keypad entry sequencer with req/ack launch and result latch.
// Optional feature: ENTRY_SEQ_REENTRY_EN (digit/enter re-entry from SHOW/ERR).
module entry_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pressed,
  input  logic [3:0] key,
  input  logic       op_ack,
  input  logic [7:0] result,
  output logic [2:0] state,
  output logic [3:0] reg0,
  output logic [3:0] reg1,
  output logic [3:0] reg2,
  output logic [3:0] reg3,
  output logic       op_req,
  output logic [7:0] res_q,
  output logic       res_valid,
  output logic       err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A_T  = 3'd1,
    A_O  = 3'd2,
    B_T  = 3'd3,
    B_O  = 3'd4,
    REQ  = 3'd5,
    SHOW = 3'd6,
    ERR  = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    reg0_d, reg1_d, reg2_d, reg3_d;
  logic [7:0]    res_q_d;
  logic          res_valid_d, op_req_d, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_digit, is_enter, is_clear;

  assign is_digit = pressed && (key <= 4'd9);
  assign is_enter = pressed && (key == 4'hE);
  assign is_clear = pressed && (key == 4'hF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      reg0      <= '0;
      reg1      <= '0;
      reg2      <= '0;
      reg3      <= '0;
      res_q     <= '0;
      res_valid <= 1'b0;
      op_req    <= 1'b0;
      err       <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      reg0      <= reg0_d;
      reg1      <= reg1_d;
      reg2      <= reg2_d;
      reg3      <= reg3_d;
      res_q     <= res_q_d;
      res_valid <= res_valid_d;
      op_req    <= op_req_d;
      err       <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    reg0_d      = reg0;
    reg1_d      = reg1;
    reg2_d      = reg2;
    reg3_d      = reg3;
    res_q_d     = res_q;
    res_valid_d = res_valid;
    cnt_d       = cnt_q;

    if (is_clear) begin
      // Clear outranks everything, including an ack arriving in the same cycle.
      state_d     = IDLE;
      reg0_d      = '0;
      reg1_d      = '0;
      reg2_d      = '0;
      reg3_d      = '0;
      res_q_d     = '0;
      res_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        IDLE, A_T: if (is_digit) begin
          reg0_d  = key;
          state_d = A_O;
        end
        A_O: if (is_digit) begin
          reg1_d  = key;
          state_d = B_T;
        end
        B_T: if (is_digit) begin
          reg2_d  = key;
          state_d = B_O;
        end
        B_O: begin
          if (is_digit) begin
            reg3_d = key;
          end else if (is_enter) begin
            state_d = REQ;
            cnt_d   = '0;
          end
        end
        REQ: begin
          if (op_ack) begin
            res_q_d     = result;
            res_valid_d = 1'b1;
            state_d     = SHOW;
          end else if (cnt_q == LAST) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef ENTRY_SEQ_REENTRY_EN
        SHOW, ERR: begin
          if (is_digit) begin
            reg0_d      = key;
            reg1_d      = '0;
            reg2_d      = '0;
            reg3_d      = '0;
            res_valid_d = 1'b0;
            state_d     = A_O;
          end else if (is_enter && state_q == SHOW) begin
            state_d = REQ;
            cnt_d   = '0;
          end
        end
`else
        SHOW, ERR: ;
`endif
        default: state_d = IDLE;
      endcase
    end

    // op_req and err are registered decodes of the next state.
    op_req_d = (state_d == REQ);
    err_d    = (state_d == ERR);
  end

  assign state = state_q;

endmodule

// File: tb/tb_entry_seq.sv
// Self-checking bench for entry_seq: vector table plus hand-written reset sequence.
module tb_entry_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       pressed;
  logic [3:0] key;
  logic       op_ack;
  logic [7:0] result;
  logic [2:0] state;
  logic [3:0] reg0, reg1, reg2, reg3;
  logic       op_req;
  logic [7:0] res_q;
  logic       res_valid;
  logic       err;

  int unsigned nvec = 0;
  int unsigned nbad = 0;

  entry_seq #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .pressed(pressed), .key(key), .op_ack(op_ack),
    .result(result), .state(state), .reg0(reg0), .reg1(reg1), .reg2(reg2),
    .reg3(reg3), .op_req(op_req), .res_q(res_q), .res_valid(res_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        p;
    logic [3:0]  k;
    logic        ack;
    logic [7:0]  res;
    logic [29:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [29:0] o(int st, int r0, int r1, int r2, int r3,
                                    int req, int rq, int rv, int er);
    return {st[2:0], r0[3:0], r1[3:0], r2[3:0], r3[3:0], req[0], rq[7:0], rv[0], er[0]};
  endfunction

  function automatic vec_t mk(logic p, logic [3:0] k, logic ack, logic [7:0] res,
                              logic [29:0] exp);
    vec_t v;
    v.p = p; v.k = k; v.ack = ack; v.res = res; v.exp = exp;
    return v;
  endfunction

  task automatic check(string name, logic [29:0] exp);
    logic [29:0] act;
    act = {state, reg0, reg1, reg2, reg3, op_req, res_q, res_valid, err};
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got {st,r0..r3,req,res_q,rv,err}=%h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(logic p, logic [3:0] k, logic ack, logic [7:0] res);
    pressed = p; key = k; op_ack = ack; result = res;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pressed = 1'b0; key = '0; op_ack = 1'b0; result = '0;

    // Entry 1,2,(E early),3,4,E then ack on the third REQ cycle.
    tbl.push_back(mk(1, 4'h1, 0, 8'h00, o(2, 1,0,0,0, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'h2, 0, 8'h00, o(3, 1,2,0,0, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'hE, 0, 8'h00, o(3, 1,2,0,0, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'h3, 0, 8'h00, o(4, 1,2,3,0, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'h4, 0, 8'h00, o(4, 1,2,3,4, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'hE, 0, 8'h00, o(5, 1,2,3,4, 1, 8'h00, 0, 0)));
    tbl.push_back(mk(0, 4'h0, 0, 8'h00, o(5, 1,2,3,4, 1, 8'h00, 0, 0)));
    tbl.push_back(mk(0, 4'h0, 0, 8'h00, o(5, 1,2,3,4, 1, 8'h00, 0, 0)));
    tbl.push_back(mk(0, 4'h0, 1, 8'h2E, o(6, 1,2,3,4, 0, 8'h2E, 1, 0)));
`ifdef ENTRY_SEQ_REENTRY_EN
    tbl.push_back(mk(1, 4'h7, 0, 8'h00, o(2, 7,0,0,0, 0, 8'h2E, 0, 0)));
`else
    tbl.push_back(mk(1, 4'h7, 0, 8'h00, o(6, 1,2,3,4, 0, 8'h2E, 1, 0)));
`endif
    tbl.push_back(mk(1, 4'hF, 0, 8'h00, o(0, 0,0,0,0, 0, 8'h00, 0, 0)));
    // 5,6,7,8,9 overwrite, enter, then timeout with TIMEOUT=4.
    tbl.push_back(mk(1, 4'h5, 0, 8'h00, o(2, 5,0,0,0, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'h6, 0, 8'h00, o(3, 5,6,0,0, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'h7, 0, 8'h00, o(4, 5,6,7,0, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'h8, 0, 8'h00, o(4, 5,6,7,8, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'h9, 0, 8'h00, o(4, 5,6,7,9, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'hE, 0, 8'h00, o(5, 5,6,7,9, 1, 8'h00, 0, 0)));
    tbl.push_back(mk(0, 4'h0, 0, 8'h00, o(5, 5,6,7,9, 1, 8'h00, 0, 0)));
    tbl.push_back(mk(0, 4'h0, 0, 8'h00, o(5, 5,6,7,9, 1, 8'h00, 0, 0)));
    tbl.push_back(mk(0, 4'h0, 0, 8'h00, o(5, 5,6,7,9, 1, 8'h00, 0, 0)));
    tbl.push_back(mk(0, 4'h0, 0, 8'h00, o(7, 5,6,7,9, 0, 8'h00, 0, 1)));
    tbl.push_back(mk(0, 4'h0, 1, 8'h55, o(7, 5,6,7,9, 0, 8'h00, 0, 1)));
    tbl.push_back(mk(1, 4'hE, 0, 8'h00, o(7, 5,6,7,9, 0, 8'h00, 0, 1)));
    tbl.push_back(mk(1, 4'hF, 0, 8'h00, o(0, 0,0,0,0, 0, 8'h00, 0, 0)));
    // Clear coincident with ack in REQ.
    tbl.push_back(mk(1, 4'h1, 0, 8'h00, o(2, 1,0,0,0, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'h2, 0, 8'h00, o(3, 1,2,0,0, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'h3, 0, 8'h00, o(4, 1,2,3,0, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'h4, 0, 8'h00, o(4, 1,2,3,4, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'hE, 0, 8'h00, o(5, 1,2,3,4, 1, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'hF, 1, 8'hAA, o(0, 0,0,0,0, 0, 8'h00, 0, 0)));
    // Stray ack, ignored keys, unpressed digit, enter in IDLE.
    tbl.push_back(mk(0, 4'h0, 1, 8'h77, o(0, 0,0,0,0, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'hA, 0, 8'h00, o(0, 0,0,0,0, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(0, 4'h5, 0, 8'h00, o(0, 0,0,0,0, 0, 8'h00, 0, 0)));
    tbl.push_back(mk(1, 4'hE, 0, 8'h00, o(0, 0,0,0,0, 0, 8'h00, 0, 0)));

    #3;
    check("reset", o(0, 0,0,0,0, 0, 8'h00, 0, 0));
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].p, tbl[i].k, tbl[i].ack, tbl[i].res);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Asynchronous reset while op_req is high; the following ack must be ignored.
    apply(1, 4'h2, 0, 8'h00);
    apply(1, 4'h3, 0, 8'h00);
    apply(1, 4'h4, 0, 8'h00);
    apply(1, 4'h5, 0, 8'h00);
    apply(1, 4'hE, 0, 8'h00);
    check("pre_rst_req", o(5, 2,3,4,5, 1, 8'h00, 0, 0));
    pressed = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_rst", o(0, 0,0,0,0, 0, 8'h00, 0, 0));
    @(posedge clk);
    #2 rst = 1'b0;
    apply(0, 4'h0, 1, 8'h99);
    check("ack_after_rst", o(0, 0,0,0,0, 0, 8'h00, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/entry_seq.md
# entry_seq

Sequencer for two-operand keypad entry. Consumes debounced key strobes, steers digits into four BCD digit slots (operand A tens/ones, operand B tens/ones), and launches one compute transaction on a req/ack handshake to the downstream arithmetic unit. It latches the returned result for the display mux and sits between the keypad scanner and the arithmetic and seven-segment datapath.

## Interface
- TIMEOUT, default 255: cycles to wait for op_ack before entering ERR; range 1..65535.
- clk  input  1  global clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- pressed  input  1  one-cycle key strobe; key is valid in the same cycle.
- key  input  4  key code: 0-9 digit, 4'hE enter, 4'hF clear, 4'hA-4'hD ignored.
- op_ack  input  1  arithmetic unit accepted the operands; result valid in the same cycle.
- result  input  8  arithmetic result, captured on op_ack.
- state  output  3  current FSM state encoding.
- reg0..reg3  output  4 each  digit slots: reg0 A tens, reg1 A ones, reg2 B tens, reg3 B ones.
- op_req  output  1  compute request.
- res_q  output  8  latched result.
- res_valid  output  1  res_q holds a fresh result.
- err  output  1  handshake timed out.

## Operation
- States: IDLE=0, A_T=1, A_O=2, B_T=3, B_O=4, REQ=5, SHOW=6, ERR=7.
- Only cycles with pressed=1 are key events. With pressed=0, key is ignored.
- Clear (4'hF) from any state: next state IDLE. All slots, res_q, res_valid, err, and op_req are cleared on the next edge.
- IDLE: a digit writes reg0 and moves to A_O. Enter is ignored.
- A_T: exists for re-entry. A digit writes reg0 and moves to A_O.
- A_O: a digit writes reg1 and moves to B_T.
- B_T: a digit writes reg2 and moves to B_O.
- B_O: a digit writes reg3 and stays in B_O. Each later digit overwrites reg3. Enter moves to REQ.
- Enter in any state other than B_O or REQ: no effect.
- REQ: op_req=1 every cycle in REQ.
  - op_ack=1 captures result into res_q, sets res_valid, and moves to SHOW. op_req is 0 from the next cycle.
  - Digit keys are ignored in REQ.
- Timeout counter: cleared on entry to REQ and incremented each REQ cycle without ack. When it reaches TIMEOUT-1 with no ack, the next state is ERR and err=1.
- ERR: err=1 and op_req=0. Only clear exits.
- op_ack outside REQ: ignored, no capture.
- Simultaneous clear key and op_ack in REQ: clear wins and the result is not captured.
- Slot and result widths are fixed. No arithmetic is done here beyond the timeout counter, sized ceil(log2(TIMEOUT+1)).

## Timing
- Reset values: state=IDLE, reg0..reg3=0, op_req=0, res_q=0, res_valid=0, err=0, timeout counter=0.
- Reset mid-transaction: op_req drops asynchronously. A later ack is ignored.
- Key to slot: a slot updates on the edge that samples pressed=1. The new value is visible the following cycle.
- Enter to op_req: op_req is high the cycle after the enter strobe.
- Ack to res_q: res_q and res_valid update on the edge sampling op_ack=1, and op_req is low the same cycle.
- op_req is a registered output. state, err, and res_valid are registered outputs.
- Maximum REQ residency is TIMEOUT cycles. err asserts at cycle TIMEOUT+1 after entering REQ.

## Configuration
- ENTRY_SEQ_REENTRY_EN defined:
  - A digit key in SHOW or ERR clears reg1..reg3, res_valid, and err. It writes the digit to reg0 and moves to A_O in one step.
  - Enter in SHOW resubmits: next state REQ, using the same operands.
- ENTRY_SEQ_REENTRY_EN undefined:
  - Digit and enter keys in SHOW are ignored.
  - Only clear leaves SHOW or ERR.

## Test plan
- Reset, then keys 1,2,3,4,E with ack 3 cycles later and result=8'h2E:
  - reg0..reg3 = 1,2,3,4.
  - op_req high exactly 3 cycles.
  - res_q=8'h2E, res_valid=1, state=SHOW.
- Keys 5,6,7,8,9 then E: reg3=9, because overwrite stays in B_O. Enter before the fourth digit produces no op_req.
- TIMEOUT=4, enter with no ack:
  - op_req high 4 cycles, then state=ERR, err=1, op_req=0.
  - A late ack has no effect.
  - Clear returns to IDLE with err=0.
- Clear key coincident with op_ack in REQ: state=IDLE, res_valid=0, res_q=0.
- rst asserted while op_req=1: all outputs return to reset values immediately and the following ack is ignored.
- With ENTRY_SEQ_REENTRY_EN defined, key 7 in SHOW: reg0=7, reg1..reg3=0, state=A_O. Undefined: state stays SHOW.
